uart_rx: RTL

Serial receiver for the 8N1 UART link, at the far end of the line from the `uart_tx` temperature transmitter. It does four things:
- synchronises the asynchronous line;
- detects and validates the start bit;
- samples the 8 data bits (LSB first) and the stop bit at bit centres;
- presents each byte on a registered valid/ack handshake, with framing-error and overrun reporting.

It sits between the board RX pin and the consumer logic, on the same 50 MHz system clock as the transmitter.

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx.sv | 133 +++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the UART receive line and the consumer-side byte handshake.
//   master : drives the serial line and rx_ack (board pin plus consumer)
//   slave  : the receiver; returns rx_data/rx_valid and the status flags
interface uart_rx_if;
    logic       uart_rx_line;   // async serial line, idles high
    logic       rx_ack;         // consumer has taken rx_data
    logic [7:0] rx_data;        // last good byte
    logic       rx_valid;       // rx_data holds an unacknowledged byte
    logic       busy;           // frame in progress (not IDLE)
    logic       frame_err;      // one-cycle pulse: stop bit sampled 0
    logic       overrun;        // sticky: unacknowledged byte overwritten

    modport master (
        output uart_rx_line, rx_ack,
        input  rx_data, rx_valid, busy, frame_err, overrun
    );
    modport slave (
        input  uart_rx_line, rx_ack,
        output rx_data, rx_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
// Synchronises the line, validates the start bit at its centre, samples
// 8 data bits (LSB first) and the stop bit at bit centres, and presents
// each good byte on a registered valid/ack handshake.
// Ports:
//   clk  : system clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : uart_rx_if.slave (line, ack in; data, valid, busy, frame_err,
//          overrun out; all outputs registered)
module uart_rx #(
    parameter int CLKS_PER_BIT = 434    // must be >= 4, matches transmitter
) (
    input  logic      clk,
    input  logic      RST,
    uart_rx_if.slave  bus
);
    localparam int            HALF = CLKS_PER_BIT / 2;
    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'(HALF - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_sync1, r_sync2;
    logic          w_rx_s;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit_idx, w_bit_idx_nxt;
    logic [7:0]    r_shreg, w_shreg_nxt;
    logic          w_load, w_ferr;

    logic [7:0]    r_rx_data;
    logic          r_rx_valid, r_busy, r_frame_err, r_overrun;

    assign w_rx_s = r_sync2;

    // Next-state / datapath decode
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shreg_nxt   = r_shreg;
        w_load        = 1'b0;
        w_ferr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                // Recheck at mid start bit; a high line here was a glitch.
                if (r_cnt == MID) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = w_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt              = '0;
                    w_shreg_nxt[r_bit_idx] = w_rx_s;
                    w_bit_idx_nxt          = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7)
                        w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is caught.
                if (r_cnt == LAST) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_BREAK: begin
                // Wait for the line to return high; a held-low line is not a start.
                if (w_rx_s)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= bus.uart_rx_line;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shreg     <= w_shreg_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_frame_err <= w_ferr;
            if (w_load)
                r_rx_data <= r_shreg;
            // A load wins over an ack in the same cycle.
            r_rx_valid  <= w_load | (r_rx_valid & ~bus.rx_ack);
            r_overrun   <= (w_load & r_rx_valid & ~bus.rx_ack) |
                           (r_overrun & ~bus.rx_ack);
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.busy      = r_busy;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
endmodule
